// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining FIB_BCD_BLANK_EN.
package fib_pkg;

  localparam int BIN_W_DEF = 11;
  localparam int NDIG_DEF  = 4;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/fib_bcd_conv_bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
// Purely combinational; one instance per output digit.
module bcd_adj3
  import fib_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble), BIN_W shifts per result.
// Define FIB_BCD_BLANK_EN to replace leading zero digits with 4'hF on load.
module fib_bcd_conv
  import fib_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              ready,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(BIN_W + 1);

  state_t           state;
  logic [BIN_W-1:0] sr;
  logic [BIN_W-1:0] sr_n;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_n;
  logic [BW-1:0]    res;
  logic [CW-1:0]    cnt;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (work[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign {work_n, sr_n} = {adj, sr} << 1;

`ifdef FIB_BCD_BLANK_EN
  logic lead;

  // Walk down from the top digit; digit 0 always shows.
  always_comb begin
    lead = 1'b1;
    res  = work_n;
    for (int i = NDIG - 1; i > 0; i--) begin
      if (lead && work_n[4*i +: 4] == 4'd0)
        res[4*i +: 4] = BLANK;
      else
        lead = 1'b0;
    end
  end
`else
  assign res = work_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      bcd   <= '0;
      sr    <= '0;
      work  <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= bin;
            work  <= '0;
            cnt   <= CW'(BIN_W);
            ready <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sr   <= sr_n;
          work <= work_n;
          cnt  <= cnt - CW'(1);
          // Last shift: publish the shifted value directly.
          if (cnt == CW'(1)) begin
            bcd   <= res;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Scoreboard bench for fib_bcd_conv: directed Fibonacci values, latency,
// back-to-back, ignored starts, held start and reset abort.
module tb_fib_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] bin;
  logic        ready;
  logic        done;
  logic [15:0] bcd;

  typedef struct {
    logic [15:0] v;
    int          t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   errs = 0;
  int   last_done = -100;
  int   gap = 0;

  fib_bcd_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pick(logic [15:0] p, logic [15:0] b);
`ifdef FIB_BCD_BLANK_EN
    return b;
`else
    return p;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      gap = cyc - last_done;
      last_done = cyc;
      if (q.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL unexpected_done got=%h exp=none", bcd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", 32'(bcd), 32'(e.v));
        chk("latency", 32'(cyc), 32'(e.t));
        chk("ready_at_done", 32'(ready), 32'd1);
      end
    end
  end

  task automatic issue(logic [10:0] b, logic [15:0] ev, bit push);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    if (push) q.push_back('{ev, cyc + 11});
    @(negedge clk);
    start = 1'b0;
    bin   = 11'($urandom);
  endtask

  task automatic wait_done();
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (done) hit = 1'b1;
    end
    if (!hit) begin
      nvec++;
      errs++;
      $display("FAIL wait_done got=timeout exp=done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 11'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    issue(11'd0, pick(16'h0000, 16'hFFF0), 1'b1);
    wait_done();

    issue(11'd34, pick(16'h0034, 16'hFF34), 1'b1);
    chk("ready_low_0", 32'(ready), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      chk("ready_low", 32'(ready), 32'd0);
      chk("bcd_hold", 32'(bcd), 32'(pick(16'h0000, 16'hFFF0)));
    end
    @(posedge clk);
    #1;
    chk("ready_back", 32'(ready), 32'd1);
    chk("done_at_11", 32'(done), 32'd1);

    issue(11'd610, pick(16'h0610, 16'hF610), 1'b1);
    wait_done();
    issue(11'd2047, 16'h2047, 1'b1);
    wait_done();
    @(negedge clk);
    chk("b2b_gap", 32'(gap), 32'd12);

    issue(11'd144, pick(16'h0144, 16'hF144), 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 11'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    issue(11'd1, pick(16'h0001, 16'hFFF1), 1'b1);
    wait_done();
    issue(11'd89, pick(16'h0089, 16'hFF89), 1'b1);
    wait_done();
    issue(11'd1597, 16'h1597, 1'b1);
    wait_done();
    issue(11'd987, pick(16'h0987, 16'hF987), 1'b1);
    wait_done();

    @(negedge clk);
    start = 1'b1;
    bin   = 11'd55;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      q.push_back('{pick(16'h0055, 16'hFF55), cyc + 11 + 12 * k});
    repeat (3) wait_done();
    @(negedge clk);
    start = 1'b0;
    chk("held_gap", 32'(gap), 32'd12);

    issue(11'd377, 16'h0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    chk("abort_idle", 32'(ready), 32'd1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/fib_bcd_conv.md
FIB_BCD_CONV -- requirements
Module: fib_bcd_conv

Interface
REQ-001 SHALL have parameter BIN_W, default 11, width of the binary Fibonacci result accepted.
REQ-002 SHALL have parameter NDIG, default 4, number of BCD output digits; 10^NDIG > 2^BIN_W-1 is required.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse; bin sampled on the same edge.
REQ-006 SHALL have port bin  input  BIN_W  unsigned binary value, driven from the Fibonacci generator's out.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a new result is loaded into bcd.
REQ-009 SHALL have port bcd  output  4*NDIG  packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-010 SHALL implement two states: IDLE and BUSY.
REQ-011 In IDLE with start=1 at an edge, SHALL capture bin into a shift register, clear the working BCD register, load iteration counter with BIN_W, enter BUSY; ready low from that edge.
REQ-012 In BUSY, each cycle SHALL add 3 to every working digit >= 5, then shift {working BCD, shift register} left by one bit (double-dabble).
REQ-013 Counter SHALL decrement each BUSY cycle; on the edge completing the BIN_W-th shift, SHALL load bcd from the working register, pulse done for one cycle, raise ready, return to IDLE.
REQ-014 Latency: start sampled at edge T0 gives bcd valid, done=1, ready=1 after edge T0+BIN_W; ready low for exactly BIN_W cycles.
REQ-015 bcd SHALL hold the previous result unchanged throughout BUSY.
REQ-016 start while BUSY (including the final BUSY cycle) SHALL be ignored; bin changes during BUSY SHALL not affect the result.
REQ-017 Back-to-back: start asserted in the first IDLE cycle after done SHALL be accepted with no dead cycle.
REQ-018 Conversion SHALL be exact for all bin in 0..2^BIN_W-1; no digit SHALL exceed 9.
REQ-019 start held high continuously SHALL start a new conversion on every IDLE cycle.

Reset
REQ-020 rst_n=0 at an edge SHALL force IDLE, ready=1, done=0, bcd=0, counter=0, working registers=0.
REQ-021 Reset during BUSY SHALL abort the conversion with no done pulse; start in the reset cycle SHALL be ignored.

Configuration
REQ-022 Macro FIB_BCD_BLANK_EN defined: on load, leading zero digits of bcd SHALL be replaced by 4'hF; digit 0 is never blanked.
REQ-023 Macro FIB_BCD_BLANK_EN undefined: bcd SHALL carry all digits including leading zeros; no blanking logic present.
REQ-024 Blanking SHALL not change latency, ready or done timing.

Structure
REQ-025 Package fib_pkg SHALL hold the default BIN_W/NDIG constants, the IDLE/BUSY state enum, and the 4'hF blank code constant.
REQ-026 Sub-module bcd_adj3 (combinational, 4-bit in/out, add 3 if >= 5) SHALL be instantiated NDIG times.

Verification
REQ-027 bin=0, start pulse -> after 11 cycles bcd=16'h0000, done pulse, ready=1.
REQ-028 bin=34 (Fibonacci n=9) -> bcd=16'h0034 exactly 11 cycles after start; ready low for those 11 cycles.
REQ-029 bin=610 then bin=2047 back-to-back (second start in first IDLE cycle) -> bcd=16'h0610 then 16'h2047, two done pulses 12 cycles apart.
REQ-030 bin=144, start; start with bin=5 on cycle 4 -> ignored, bcd=16'h0144, single done pulse.
REQ-031 bin=377, start; rst_n=0 on cycle 6 -> no done, bcd=16'h0000, ready=1 after reset edge.
REQ-032 FIB_BCD_BLANK_EN defined: bin=34 -> bcd=16'hFF34; bin=0 -> bcd=16'hFFF0; bin=1597 -> bcd=16'h1597.
